// File: rtl/rr_stream_mux_if.sv
// ============================================================================
// rr_stream_mux_if : stream bundle for rr_stream_mux (NCH inputs, one output)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rr_stream_mux_if #(
   parameter int WIDTH = 4,
   parameter int NCH   = 4
);
   logic [NCH-1:0]       in_valid;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_last;
   logic [NCH-1:0]       in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [$clog2(NCH)-1:0] out_ch;
   logic                 out_ready;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

`default_nettype wire

// File: rtl/rr_stream_mux.sv
// ============================================================================
// rr_stream_mux : round-robin N:1 stream mux with a single registered output
// Optional packet lock via macro RR_MUX_PKT_LOCK_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module rr_stream_mux #(
   parameter int WIDTH = 4,
   parameter int NCH   = 4
) (
   input  logic clk,
   input  logic rst_n,
   rr_stream_mux_if.slave s
);
   localparam int CW = $clog2(NCH);
   localparam logic [CW-1:0] C_LAST_RST = CW'(NCH - 1);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [CW-1:0]    out_ch_q,    out_ch_d;
   logic [CW-1:0]    last_q,      last_d;

   logic             load_en;
   logic             xfer;
   logic             grant_found;
   logic [CW-1:0]    grant;
   logic [WIDTH-1:0] grant_data;
   logic [NCH-1:0]   ready_vec;

`ifdef RR_MUX_PKT_LOCK_EN
   typedef enum logic [0:0] {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   lock_state_t   lock_q, lock_d;
   logic [CW-1:0] lock_ch_q, lock_ch_d;
   logic          grant_last;
`else
   logic unused_last;
   assign unused_last = ^s.in_last;
`endif

   // Walk distances NCH..1 so the nearest valid channel after last_q wins.
   always_comb begin
      grant_found = 1'b0;
      grant       = '0;
      for (int k = NCH; k >= 1; k--) begin
         for (int i = 0; i < NCH; i++) begin
            if (i == (int'(last_q) + k) % NCH && s.in_valid[i]) begin
               grant_found = 1'b1;
               grant       = CW'(i);
            end
         end
      end
`ifdef RR_MUX_PKT_LOCK_EN
      if (lock_q == LOCKED) begin
         grant       = lock_ch_q;
         grant_found = 1'b0;
         for (int i = 0; i < NCH; i++) begin
            if (CW'(i) == lock_ch_q) grant_found = s.in_valid[i];
         end
      end
`endif
   end

   always_comb begin
      grant_data = '0;
`ifdef RR_MUX_PKT_LOCK_EN
      grant_last = 1'b0;
`endif
      for (int i = 0; i < NCH; i++) begin
         if (grant == CW'(i)) begin
            grant_data = s.in_data[i*WIDTH +: WIDTH];
`ifdef RR_MUX_PKT_LOCK_EN
            grant_last = s.in_last[i];
`endif
         end
      end
   end

   assign load_en = !out_valid_q || s.out_ready;
   // Gating with rst_n keeps every in_ready low while reset is held.
   assign xfer    = rst_n && load_en && grant_found;

   always_comb begin
      ready_vec = '0;
      for (int i = 0; i < NCH; i++) begin
         ready_vec[i] = xfer && (grant == CW'(i));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      last_d      = last_q;
      if (load_en) begin
         out_valid_d = grant_found;
         if (grant_found) begin
            out_data_d = grant_data;
            out_ch_d   = grant;
            last_d     = grant;
         end
      end
   end

`ifdef RR_MUX_PKT_LOCK_EN
   always_comb begin
      lock_d    = lock_q;
      lock_ch_d = lock_ch_q;
      if (xfer) begin
         case (lock_q)
            UNLOCKED: begin
               if (!grant_last) begin
                  lock_d    = LOCKED;
                  lock_ch_d = grant;
               end
            end
            LOCKED: begin
               if (grant_last) lock_d = UNLOCKED;
            end
            default: lock_d = UNLOCKED;
         endcase
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         last_q      <= C_LAST_RST;
`ifdef RR_MUX_PKT_LOCK_EN
         lock_q      <= UNLOCKED;
         lock_ch_q   <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         last_q      <= last_d;
`ifdef RR_MUX_PKT_LOCK_EN
         lock_q      <= lock_d;
         lock_ch_q   <= lock_ch_d;
`endif
      end
   end

   assign s.in_ready  = ready_vec;
   assign s.out_valid = out_valid_q;
   assign s.out_data  = out_data_q;
   assign s.out_ch    = out_ch_q;

endmodule

`default_nettype wire

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel.
REQ-002 Parameter NCH, default 4, number of input channels; legal range 2..16.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  NCH  per-channel word-valid.
REQ-006 Port in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_last  input  NCH  per-channel end-of-packet marker; used only under REQ-031.
REQ-008 Port in_ready  output  NCH  per-channel accept; at most one bit high.
REQ-009 Port out_valid  output  1  output register holds a word.
REQ-010 Port out_data  output  WIDTH  registered selected word.
REQ-011 Port out_ch  output  $clog2(NCH)  index of the channel that supplied out_data.
REQ-012 Port out_ready  input  1  downstream accept.

Function
REQ-013 Output stage SHALL be one registered entry; load_en = !out_valid || out_ready.
REQ-014 A transfer on channel i SHALL occur when in_valid[i] && in_ready[i] in the same cycle.
REQ-015 in_ready[i] SHALL be combinational: load_en && in_valid[i] && (grant == i).
REQ-016 grant SHALL be the first channel with in_valid set, searching upward from (last+1) mod NCH with wrap-around, where last is the registered index of the most recent transfer.
REQ-017 On a transfer, out_data/out_ch SHALL update at the next edge (latency 1 cycle), out_valid SHALL be 1, and last SHALL take the granted index.
REQ-018 If load_en and no in_valid bit is set, out_valid SHALL go to 0 at the next edge; out_data/out_ch SHALL hold.
REQ-019 If out_valid && !out_ready, out_valid, out_data, out_ch and last SHALL hold and all in_ready SHALL be 0.
REQ-020 Simultaneous out_ready and new transfer SHALL replace the word in one cycle, giving full throughput of one word per clock.
REQ-021 With all NCH channels continuously valid and out_ready = 1, grants SHALL rotate 0,1,...,NCH-1,0 with no channel skipped or repeated.
REQ-022 A channel dropping in_valid SHALL be skipped without a bubble if any other channel is valid.
REQ-023 Words from one channel SHALL leave in arrival order; no word SHALL be duplicated or dropped.

Reset
REQ-024 While rst_n = 0: out_valid = 0, out_data = 0, out_ch = 0, last = NCH-1, lock state = UNLOCKED, all in_ready = 0.
REQ-025 After reset, channel 0 SHALL have highest priority for the first grant.
REQ-026 Reset asserted mid-transfer SHALL discard the output word immediately, without waiting for a clock edge.
REQ-027 The first transfer SHALL be possible on the first rising edge after rst_n rises.

Configuration
REQ-028 Macro RR_MUX_PKT_LOCK_EN selects packet-lock mode.
REQ-029 Without the macro, in_last SHALL be ignored and arbitration SHALL be per word (REQ-016).
REQ-030 With the macro, a two-state FSM SHALL apply: UNLOCKED and LOCKED(ch).
REQ-031 UNLOCKED: grant per REQ-016. A transfer with in_last = 0 SHALL go to LOCKED(granted ch); in_last = 1 SHALL stay UNLOCKED.
REQ-032 LOCKED(ch): grant SHALL be ch only, with other channels blocked even when valid and ch is idle. A transfer with in_last = 1 SHALL return to UNLOCKED with last = ch.
REQ-033 A single-word packet (in_last = 1 on first word) SHALL not lock.

Verification
REQ-034 NCH=4, WIDTH=4, all channels valid with data i+1, out_ready=1 for 8 cycles -> out_ch 0,1,2,3,0,1,2,3 with out_data 1,2,3,4,1,2,3,4 and out_valid continuously high.
REQ-035 Channel 2 only valid with data 0xA, out_ready=0 for 3 cycles, then 1 -> out_valid high from the edge after the first transfer, out_data=0xA held, in_ready[2]=0 during the stall, and the next word accepted in the release cycle.
REQ-036 Channels 1 and 3 valid, last=1 -> grant 3, then 1, then 3; channels 0 and 2 never granted.
REQ-037 rst_n pulled low asynchronously while out_valid=1 -> out_valid=0 before the next clk edge; after release, first grant is channel 0 when all channels are valid.
REQ-038 RR_MUX_PKT_LOCK_EN defined, ch1 sends 3 words (in_last on the third) while ch0 is continuously valid -> out_ch 1,1,1 then 0. Without the macro, the same stimulus -> out_ch alternates 1,0,1,0.
